// File: rtl/pipo_ureg.sv
// Parametrised universal register: load, clear, add, inc/dec, shift and rotate,
// with registered zero/carry/overflow flags. All state changes on the rising edge
// of clk; clr_n is a synchronous active-low reset.
module pipo_ureg #(
  parameter int unsigned      WIDTH   = 16,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  parameter bit               SAT     = 1'b0
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             ld,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] din,
  input  logic             sin,
  output logic [WIDTH-1:0] dout,
  output logic             zero,
  output logic             cout,
  output logic             ovf
);

  localparam logic [2:0] OpHold  = 3'b000;
  localparam logic [2:0] OpAdd   = 3'b001;
  localparam logic [2:0] OpDec   = 3'b010;
  localparam logic [2:0] OpInc   = 3'b011;
  localparam logic [2:0] OpShl   = 3'b100;
  localparam logic [2:0] OpShr   = 3'b101;
  localparam logic [2:0] OpRotl  = 3'b110;
  localparam logic [2:0] OpClear = 3'b111;

  localparam logic [WIDTH-1:0] One = WIDTH'(1);

  logic [WIDTH-1:0] dout_q, dout_d;
  logic             zero_q;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH:0]   sum;
  logic             borrow;
  logic             carry_inc;

  // Shared arithmetic terms; the carry out of the add is the extra MSB.
  always_comb begin
    sum       = {1'b0, dout_q} + {1'b0, din};
    borrow    = (dout_q == '0);
    carry_inc = &dout_q;
  end

  // Next-state decode: ld has priority over op.
  always_comb begin
    dout_d = dout_q;
    cout_d = cout_q;
    ovf_d  = ovf_q;
    if (ld) begin
      dout_d = din;
      cout_d = 1'b0;
      ovf_d  = 1'b0;
    end else begin
      case (op)
        OpHold: begin
          dout_d = dout_q;
        end
        OpAdd: begin
          dout_d = (SAT && sum[WIDTH]) ? '1 : sum[WIDTH-1:0];
          cout_d = sum[WIDTH];
          ovf_d  = sum[WIDTH];
        end
        OpDec: begin
          dout_d = (SAT && borrow) ? '0 : dout_q - One;
          cout_d = borrow;
          ovf_d  = borrow;
        end
        OpInc: begin
          dout_d = (SAT && carry_inc) ? '1 : dout_q + One;
          cout_d = carry_inc;
          ovf_d  = carry_inc;
        end
        OpShl: begin
          dout_d = {dout_q[WIDTH-2:0], sin};
          cout_d = dout_q[WIDTH-1];
          ovf_d  = 1'b0;
        end
        OpShr: begin
          dout_d = {sin, dout_q[WIDTH-1:1]};
          cout_d = dout_q[0];
          ovf_d  = 1'b0;
        end
        OpRotl: begin
          dout_d = {dout_q[WIDTH-2:0], dout_q[WIDTH-1]};
          cout_d = dout_q[WIDTH-1];
          ovf_d  = 1'b0;
        end
        OpClear: begin
          dout_d = '0;
          cout_d = 1'b0;
          ovf_d  = 1'b0;
        end
        default: begin
          dout_d = dout_q;
        end
      endcase
    end
  end

  // State update; zero is derived from the value being written so it never lags dout.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      dout_q <= RST_VAL;
      zero_q <= (RST_VAL == '0);
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      dout_q <= dout_d;
      zero_q <= (dout_d == '0);
      cout_q <= cout_d;
      ovf_q  <= ovf_d;
    end
  end

  assign dout = dout_q;
  assign zero = zero_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_pipo_ureg.sv
// Self-checking bench for pipo_ureg: five instances (16-bit wrap, 16-bit counter,
// 16-bit saturating with nonzero reset value, 8-bit wrap, 8-bit saturating).
module tb_pipo_ureg;

  localparam int IA = 0;  // 16-bit wrap, shared inputs
  localparam int IB = 1;  // 16-bit wrap, private inputs (down-counter)
  localparam int IS = 2;  // 16-bit saturating, RST_VAL = 00A5
  localparam int IW = 3;  // 8-bit wrap
  localparam int IX = 4;  // 8-bit saturating

  logic        clk = 1'b0;
  logic        clr_n;
  logic        ld;
  logic [2:0]  op;
  logic [15:0] din;
  logic        sin;
  logic        ld_b;
  logic [2:0]  op_b;
  logic [15:0] din_b;

  logic [15:0] a_dout, b_dout, s_dout;
  logic [7:0]  w_dout, x_dout;
  logic a_z, a_c, a_o, b_z, b_c, b_o, s_z, s_c, s_o, w_z, w_c, w_o, x_z, x_c, x_o;

  always #5 clk = ~clk;

  pipo_ureg #(.WIDTH(16), .RST_VAL(16'h0000), .SAT(1'b0)) u_a (
    .clk(clk), .clr_n(clr_n), .ld(ld), .op(op), .din(din), .sin(sin),
    .dout(a_dout), .zero(a_z), .cout(a_c), .ovf(a_o)
  );
  pipo_ureg #(.WIDTH(16), .RST_VAL(16'h0000), .SAT(1'b0)) u_b (
    .clk(clk), .clr_n(clr_n), .ld(ld_b), .op(op_b), .din(din_b), .sin(1'b0),
    .dout(b_dout), .zero(b_z), .cout(b_c), .ovf(b_o)
  );
  pipo_ureg #(.WIDTH(16), .RST_VAL(16'h00A5), .SAT(1'b1)) u_s (
    .clk(clk), .clr_n(clr_n), .ld(ld), .op(op), .din(din), .sin(sin),
    .dout(s_dout), .zero(s_z), .cout(s_c), .ovf(s_o)
  );
  pipo_ureg #(.WIDTH(8), .RST_VAL(8'h00), .SAT(1'b0)) u_w (
    .clk(clk), .clr_n(clr_n), .ld(ld), .op(op), .din(din[7:0]), .sin(sin),
    .dout(w_dout), .zero(w_z), .cout(w_c), .ovf(w_o)
  );
  pipo_ureg #(.WIDTH(8), .RST_VAL(8'h00), .SAT(1'b1)) u_x (
    .clk(clk), .clr_n(clr_n), .ld(ld), .op(op), .din(din[7:0]), .sin(sin),
    .dout(x_dout), .zero(x_z), .cout(x_c), .ovf(x_o)
  );

  typedef struct {
    logic        ld;
    logic [2:0]  op;
    logic [15:0] din;
    logic        sin;
    logic [15:0] d;
    logic        c;
    logic        o;
    logic        z;
  } vec_t;

  typedef struct {
    string       nm;
    int          inst;
    logic [15:0] d;
    logic        c;
    logic        o;
    logic        z;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic vec_t mk(logic l, logic [2:0] o, logic [15:0] di, logic s,
                              logic [15:0] d, logic c, logic ov, logic z);
    vec_t v;
    v.ld = l; v.op = o; v.din = di; v.sin = s;
    v.d = d; v.c = c; v.o = ov; v.z = z;
    return v;
  endfunction

  function automatic logic [18:0] act(int inst);
    case (inst)
      IA:      return {a_dout, a_c, a_o, a_z};
      IB:      return {b_dout, b_c, b_o, b_z};
      IS:      return {s_dout, s_c, s_o, s_z};
      IW:      return {8'h00, w_dout, w_c, w_o, w_z};
      IX:      return {8'h00, x_dout, x_c, x_o, x_z};
      default: return '0;
    endcase
  endfunction

  task automatic drive(logic l, logic [2:0] o, logic [15:0] di, logic s);
    ld = l; op = o; din = di; sin = s;
  endtask

  task automatic expect_out(string nm, int inst, logic [15:0] d, logic c, logic o,
                            logic z);
    exp_t e;
    e.nm = nm; e.inst = inst; e.d = d; e.c = c; e.o = o; e.z = z;
    sb.push_back(e);
  endtask

  // Advance one edge, then retire every pending expectation against the DUT.
  task automatic tick();
    exp_t        e;
    logic [18:0] got;
    @(posedge clk);
    #1;
    while (sb.size() != 0) begin
      e   = sb.pop_front();
      got = act(e.inst);
      n_tests++;
      if (got !== {e.d, e.c, e.o, e.z}) begin
        n_fail++;
        $display("FAIL %s (inst %0d): got dout=%h cout=%b ovf=%b zero=%b, want dout=%h cout=%b ovf=%b zero=%b",
                 e.nm, e.inst, got[18:3], got[2], got[1], got[0], e.d, e.c, e.o, e.z);
      end
    end
  endtask

  // Control inputs must never be unknown while out of reset.
  always @(negedge clk) begin
    if (clr_n === 1'b1 && $isunknown({ld, op, ld_b, op_b})) begin
      n_fail++;
      $display("FAIL x_on_control: ld=%b op=%b ld_b=%b op_b=%b", ld, op, ld_b, op_b);
    end
  end

  initial begin
    int k;
    clr_n = 1'b0; ld = 1'b0; op = 3'd0; din = '0; sin = 1'b0;
    ld_b = 1'b0; op_b = 3'd0; din_b = '0;

    tbl.push_back(mk(1'b1, 3'd0, 16'h0005, 1'b0, 16'h0005, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 3'd1, 16'h0003, 1'b0, 16'h0008, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 3'd3, 16'h0000, 1'b0, 16'h0009, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 3'd2, 16'h0000, 1'b0, 16'h0008, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 3'd0, 16'hFFFF, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 3'd3, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1));
    tbl.push_back(mk(1'b0, 3'd4, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 3'd0, 16'hFFFF, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 3'd2, 16'h0000, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 3'd0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 3'd2, 16'h0000, 1'b0, 16'hFFFF, 1'b1, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 3'd1, 16'h0002, 1'b0, 16'h0001, 1'b1, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 3'd0, 16'h5555, 1'b1, 16'h0001, 1'b1, 1'b1, 1'b0));
    tbl.push_back(mk(1'b1, 3'd0, 16'h8001, 1'b0, 16'h8001, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 3'd4, 16'h0000, 1'b0, 16'h0002, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 3'd0, 16'h8001, 1'b0, 16'h8001, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 3'd5, 16'h0000, 1'b1, 16'hC000, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 3'd0, 16'h8001, 1'b0, 16'h8001, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 3'd6, 16'h0000, 1'b0, 16'h0003, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 3'd7, 16'hABCD, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1));
    tbl.push_back(mk(1'b1, 3'd7, 16'h1234, 1'b0, 16'h1234, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 3'd5, 16'h0000, 1'b0, 16'h091A, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 3'd6, 16'h0000, 1'b0, 16'h1234, 1'b0, 1'b0, 1'b0));

    @(posedge clk);
    #1;

    // Reset overrides a pending load and add.
    clr_n = 1'b0;
    drive(1'b1, 3'd1, 16'hBEEF, 1'b0);
    expect_out("reset_a", IA, 16'h0000, 1'b0, 1'b0, 1'b1);
    expect_out("reset_b", IB, 16'h0000, 1'b0, 1'b0, 1'b1);
    expect_out("reset_s_rstval", IS, 16'h00A5, 1'b0, 1'b0, 1'b0);
    expect_out("reset_w8", IW, 16'h0000, 1'b0, 1'b0, 1'b1);
    expect_out("reset_x8", IX, 16'h0000, 1'b0, 1'b0, 1'b1);
    tick();
    clr_n = 1'b1;
    drive(1'b1, 3'd0, 16'h0005, 1'b0);
    expect_out("load_after_reset", IA, 16'h0005, 1'b0, 1'b0, 1'b0);
    tick();

    // Repeated-addition multiply: product on u_a, down-counter on u_b.
    drive(1'b1, 3'd0, 16'h0000, 1'b0);
    ld_b = 1'b1; op_b = 3'd0; din_b = 16'h0003;
    expect_out("mul_load_prod", IA, 16'h0000, 1'b0, 1'b0, 1'b1);
    expect_out("mul_load_cnt", IB, 16'h0003, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 3'd1, 16'h0007, 1'b0);
    ld_b = 1'b0; op_b = 3'd2;
    k = 0;
    while (b_z !== 1'b1 && k < 10) begin
      k++;
      expect_out("mul_prod", IA, 16'(7 * k), 1'b0, 1'b0, 1'b0);
      expect_out("mul_cnt", IB, 16'(3 - k), 1'b0, 1'b0, (k == 3));
      tick();
    end
    op_b = 3'd0;
    n_tests++;
    if (k != 3) begin
      n_fail++;
      $display("FAIL mul_iterations: got %0d edges, want 3", k);
    end

    // Wrap vs saturate, 16-bit and 8-bit.
    drive(1'b1, 3'd0, 16'hFFFF, 1'b0);
    expect_out("ld_ffff_a", IA, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    expect_out("ld_ffff_s", IS, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 3'd3, 16'h0000, 1'b0);
    expect_out("inc_wrap", IA, 16'h0000, 1'b1, 1'b1, 1'b1);
    expect_out("inc_sat", IS, 16'hFFFF, 1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b1, 3'd0, 16'h0000, 1'b0);
    expect_out("ld_zero_a", IA, 16'h0000, 1'b0, 1'b0, 1'b1);
    expect_out("ld_zero_s", IS, 16'h0000, 1'b0, 1'b0, 1'b1);
    tick();
    drive(1'b0, 3'd2, 16'h0000, 1'b0);
    expect_out("dec_wrap", IA, 16'hFFFF, 1'b1, 1'b1, 1'b0);
    expect_out("dec_sat", IS, 16'h0000, 1'b1, 1'b1, 1'b1);
    tick();
    drive(1'b1, 3'd0, 16'hFFF0, 1'b0);
    expect_out("ld_fff0_a", IA, 16'hFFF0, 1'b0, 1'b0, 1'b0);
    expect_out("ld_f0_w8", IW, 16'h00F0, 1'b0, 1'b0, 1'b0);
    expect_out("ld_f0_x8", IX, 16'h00F0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 3'd1, 16'h0020, 1'b0);
    expect_out("add_wrap16", IA, 16'h0010, 1'b1, 1'b1, 1'b0);
    expect_out("add_sat16", IS, 16'hFFFF, 1'b1, 1'b1, 1'b0);
    expect_out("add_wrap8", IW, 16'h0010, 1'b1, 1'b1, 1'b0);
    expect_out("add_sat8", IX, 16'h00FF, 1'b1, 1'b1, 1'b0);
    tick();

    // Table of single-edge operations on the 16-bit wrapping instance.
    foreach (tbl[i]) begin
      drive(tbl[i].ld, tbl[i].op, tbl[i].din, tbl[i].sin);
      expect_out($sformatf("vec%0d", i), IA, tbl[i].d, tbl[i].c, tbl[i].o, tbl[i].z);
      tick();
    end

    // Reset in the middle of an add chain discards the add.
    drive(1'b1, 3'd0, 16'h0001, 1'b0);
    expect_out("chain_ld", IA, 16'h0001, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 3'd1, 16'h0001, 1'b0);
    expect_out("chain_add", IA, 16'h0002, 1'b0, 1'b0, 1'b0);
    tick();
    clr_n = 1'b0;
    expect_out("mid_reset_a", IA, 16'h0000, 1'b0, 1'b0, 1'b1);
    expect_out("mid_reset_s", IS, 16'h00A5, 1'b0, 1'b0, 1'b0);
    expect_out("mid_reset_w8", IW, 16'h0000, 1'b0, 1'b0, 1'b1);
    tick();
    clr_n = 1'b1;
    drive(1'b1, 3'd0, 16'hFFFF, 1'b0);
    expect_out("pre_hold_ld", IA, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 3'd3, 16'h0000, 1'b0);
    expect_out("pre_hold_inc_a", IA, 16'h0000, 1'b1, 1'b1, 1'b1);
    expect_out("pre_hold_inc_s", IS, 16'hFFFF, 1'b1, 1'b1, 1'b0);
    tick();
    for (int h = 0; h < 5; h++) begin
      drive(1'b0, 3'd0, 16'(h * 16'h1111), h[0]);
      expect_out($sformatf("hold%0d_a", h), IA, 16'h0000, 1'b1, 1'b1, 1'b1);
      expect_out($sformatf("hold%0d_s", h), IS, 16'hFFFF, 1'b1, 1'b1, 1'b0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
